// File: rtl/spi_pwm_reg_ctrl.sv
// SPI-peripheral write-only register file for the PWM block: oversamples SCLK/nCS/COPI
// in the clk domain, frames 16-bit writes and commits them to five configuration registers.
module spi_pwm_reg_ctrl #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FRAME_BITS  = 16,
   parameter int unsigned MAX_ADDR    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk,
   input  logic       ncs,
   input  logic       copi,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle,
   output logic       wr_strobe,
   output logic       frame_err
);

   localparam int unsigned CW = $clog2(FRAME_BITS + 2);
   localparam int unsigned AW = FRAME_BITS - 9;

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

   logic [SYNC_STAGES-1:0] r_sclk_sync, r_ncs_sync, r_copi_sync;
   logic                   r_sclk_prev, r_ncs_prev;
   state_t                 r_state;
   logic [CW-1:0]          r_cnt;
   logic [FRAME_BITS-1:0]  r_shift;
   logic [7:0]             r_reg [0:4];
   logic                   r_wr_strobe, r_frame_err;

   logic          w_sclk, w_ncs, w_copi;
   logic          w_sclk_rise, w_ncs_fall, w_ncs_rise;
   logic          w_rw, w_addr_ok;
   logic [AW-1:0] w_addr;
   logic [7:0]    w_data;

   assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
   assign w_ncs       = r_ncs_sync[SYNC_STAGES-1];
   assign w_copi      = r_copi_sync[SYNC_STAGES-1];
   assign w_sclk_rise = w_sclk & ~r_sclk_prev;
   assign w_ncs_fall  = ~w_ncs & r_ncs_prev;
   assign w_ncs_rise  = w_ncs & ~r_ncs_prev;

   assign w_rw      = r_shift[FRAME_BITS-1];
   assign w_addr    = r_shift[FRAME_BITS-2:8];
   assign w_data    = r_shift[7:0];
   assign w_addr_ok = (w_addr <= AW'(MAX_ADDR)) && (w_addr <= AW'(4));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sclk_sync <= '0;
         r_ncs_sync  <= '1;
         r_copi_sync <= '0;
         r_sclk_prev <= 1'b0;
         r_ncs_prev  <= 1'b1;
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_shift     <= '0;
         r_wr_strobe <= 1'b0;
         r_frame_err <= 1'b0;
         for (int unsigned i = 0; i < 5; i++) r_reg[i] <= '0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
         r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
         r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
         r_sclk_prev <= w_sclk;
         // Holding the nCS history through COMMIT lets a fall seen there start the next frame from IDLE
         if (r_state != COMMIT) r_ncs_prev <= w_ncs;
         r_wr_strobe <= 1'b0;
         r_frame_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_ncs_fall) begin
                  r_state <= SHIFT;
                  r_cnt   <= '0;
                  r_shift <= '0;
               end
            end
            SHIFT: begin
               if (w_ncs_rise) begin
                  r_state <= COMMIT;
               end else if (w_ncs_fall) begin
                  r_cnt   <= '0;
                  r_shift <= '0;
               end else if (w_sclk_rise && !w_ncs) begin
                  r_shift <= {r_shift[FRAME_BITS-2:0], w_copi};
                  if (r_cnt != CW'(FRAME_BITS + 1)) r_cnt <= r_cnt + 1'b1;
               end
            end
            COMMIT: begin
               r_state <= IDLE;
               if (r_cnt == CW'(FRAME_BITS)) begin
                  if (w_rw && w_addr_ok) begin
                     r_reg[w_addr[2:0]] <= w_data;
                     r_wr_strobe        <= 1'b1;
                  end
               end else begin
                  r_frame_err <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign en_reg_out_7_0  = r_reg[0];
   assign en_reg_out_15_8 = r_reg[1];
   assign en_reg_pwm_7_0  = r_reg[2];
   assign en_reg_pwm_15_8 = r_reg[3];
   assign pwm_duty_cycle  = r_reg[4];
   assign wr_strobe       = r_wr_strobe;
   assign frame_err       = r_frame_err;

endmodule

// File: tb/tb_spi_pwm_reg_ctrl.sv
// Bench for spi_pwm_reg_ctrl: directed and random SPI frames at sclk = clk/8, checked against
// a frame-level model (bits collected per nCS-low window, decoded when nCS rises).
module tb_spi_pwm_reg_ctrl;

   localparam int SYNC = 2;

   logic       clk = 1'b0;
   logic       rst_n, sclk, ncs, copi;
   logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
   logic       wr_strobe, frame_err;

   spi_pwm_reg_ctrl #(.SYNC_STAGES(SYNC), .FRAME_BITS(16), .MAX_ADDR(4)) dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .ncs(ncs), .copi(copi),
      .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
      .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
      .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int   n_cmp = 0, n_bad = 0;
   int   cyc = 0, n_str = 0, n_err = 0;
   int   exp_str = 0, exp_err = 0;
   logic [7:0] exp_reg [5];
   bit   q[$];
   bit   rise_at[int];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Pulse monitor: strobes must land SYNC+2 clocks after some nCS rise
   always @(negedge clk) begin
      cyc++;
      if (wr_strobe) begin
         n_str++;
         chk("strobe_latency", 32'(rise_at.exists(cyc - (SYNC + 2))), 32'd1);
      end
      if (frame_err) n_err++;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   function automatic void model_close();
      logic [15:0] w = '0;
      if (q.size() != 16) begin
         exp_err++;
      end else begin
         for (int i = 0; i < 16; i++) w = {w[14:0], q[i]};
         if (w[15] && w[14:8] <= 7'd4) begin
            exp_reg[w[10:8]] = w[7:0];
            exp_str++;
         end
      end
      q.delete();
   endfunction

   task automatic ncs_low();
      ncs = 1'b0;
      q.delete();
      wait_clk(4);
   endtask

   task automatic ncs_high();
      ncs = 1'b1;
      rise_at[cyc] = 1'b1;
      model_close();
   endtask

   task automatic send_bits(input logic [31:0] w, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         copi = w[nbits-1-i];
         wait_clk(4);
         sclk = 1'b1;
         q.push_back(copi);
         wait_clk(4);
         sclk = 1'b0;
      end
   endtask

   task automatic frame(input logic [31:0] w, input int nbits);
      ncs_low();
      send_bits(w, nbits);
      wait_clk(4);
      ncs_high();
   endtask

   task automatic check_all(input string tag);
      wait_clk(10);
      chk({tag, " reg0"}, 32'(en_reg_out_7_0),  32'(exp_reg[0]));
      chk({tag, " reg1"}, 32'(en_reg_out_15_8), 32'(exp_reg[1]));
      chk({tag, " reg2"}, 32'(en_reg_pwm_7_0),  32'(exp_reg[2]));
      chk({tag, " reg3"}, 32'(en_reg_pwm_15_8), 32'(exp_reg[3]));
      chk({tag, " reg4"}, 32'(pwm_duty_cycle),  32'(exp_reg[4]));
      chk({tag, " strobes"}, 32'(n_str), 32'(exp_str));
      chk({tag, " errs"},    32'(n_err), 32'(exp_err));
   endtask

   initial begin
      logic [15:0] w;
      int nb;
      rst_n = 1'b0; sclk = 1'b0; ncs = 1'b1; copi = 1'b0;
      for (int i = 0; i < 5; i++) exp_reg[i] = 8'h00;
      wait_clk(5);
      rst_n = 1'b1;
      wait_clk(20);
      check_all("reset");

      frame(32'h80F0, 16); check_all("wr0");
      frame(32'h81A5, 16); check_all("wr1");
      frame(32'h8233, 16); check_all("wr2");
      frame(32'h83CC, 16); check_all("wr3");
      frame(32'h8480, 16); check_all("wr4");

      frame(32'h0455, 16); check_all("read");
      frame(32'h8599, 16); check_all("addr5");

      frame(32'h80FF >> 6, 10);   check_all("short");
      frame(32'h101FF, 17);       check_all("long");

      // One-clock nCS glitch after a partial frame, then a full write
      ncs_low();
      send_bits(32'h80AA >> 10, 6);
      wait_clk(4);
      ncs_high();
      wait_clk(1);
      ncs_low();
      send_bits(32'h8442, 16);
      wait_clk(4);
      ncs_high();
      check_all("glitch");

      // Reset mid-frame: the remaining bits form a fresh, short window
      ncs_low();
      send_bits(32'h81, 8);
      rst_n = 1'b0;
      wait_clk(3);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) exp_reg[i] = 8'h00;
      q.delete();
      send_bits(32'h77, 8);
      wait_clk(4);
      ncs_high();
      check_all("midreset");

      frame(32'h8011, 16);
      wait_clk(2);
      frame(32'h8022, 16);
      check_all("b2b");

      for (int k = 0; k < 40; k++) begin
         w[15]   = ($urandom_range(0, 3) != 0);
         w[14:8] = 7'($urandom_range(0, 6));
         w[7:0]  = 8'($urandom);
         nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 16;
         frame({16'h0, w}, nb);
         wait_clk($urandom_range(2, 6));
         check_all($sformatf("rand%0d", k));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
